// File: rtl/replica_unloader.sv
// Receives the replica route stream at the end of the shift chain, buffers it, checks each
// route for a valid city permutation and plays the buffer back over a valid/ready port.
module replica_unloader #(
    parameter int REPLICA_NUM = 4,
    parameter int CITY_DIV    = 4,
    parameter int LANES       = 8,
    parameter int CITY_W      = 7
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            in_valid,
    input  logic [LANES*CITY_W-1:0]         in_data,
    output logic                            rd_valid,
    input  logic                            rd_ready,
    output logic [LANES*CITY_W-1:0]         rd_data,
    output logic [$clog2(REPLICA_NUM)-1:0]  rd_replica,
    output logic [$clog2(CITY_DIV)-1:0]     rd_beat,
    output logic                            rd_last,
    output logic                            capture_done,
    output logic [REPLICA_NUM-1:0]          perm_err,
    output logic                            overrun,
    output logic                            busy
);
    localparam int RW       = $clog2(REPLICA_NUM);
    localparam int BW       = $clog2(CITY_DIV);
    localparam int AW       = RW + BW;
    localparam int DW       = LANES * CITY_W;
    localparam int CITY_NUM = CITY_DIV * LANES;
    localparam int SW       = $clog2(CITY_NUM);
    localparam logic [RW-1:0] REP_MAX  = RW'(REPLICA_NUM - 1);
    localparam logic [BW-1:0] BEAT_MAX = BW'(CITY_DIV - 1);

    typedef enum logic [1:0] {IDLE, CAPT, READ, DONE} state_t;

    state_t state, state_next;

    // Address is {replica, beat}; a non-power-of-two CITY_DIV just leaves holes unused.
    logic [DW-1:0] mem [0:(1<<AW)-1];

    logic [RW-1:0]       replica_cnt, fetch_rep, pend_rep, skid_rep;
    logic [BW-1:0]       beat_cnt, fetch_beat, pend_beat, skid_beat;
    logic                fetch_all, pend_valid, skid_valid;
    logic [DW-1:0]       pend_data, skid_data;
    logic [CITY_NUM-1:0] seen, seen_next;
    logic                beat_err;
    logic                cap_en, cap_last, pop, fetch_en;
    logic [1:0]          occ;
    logic [CITY_W-1:0]   city;

    assign busy    = (state != IDLE);
    assign rd_last = rd_valid && (rd_replica == REP_MAX) && (rd_beat == BEAT_MAX);
    assign pop     = rd_valid && rd_ready;
    // Words held or in flight once this edge's pop is retired; the skid keeps this <= 2.
    assign occ     = 2'(rd_valid) + 2'(skid_valid) + 2'(pend_valid) - 2'(pop);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cap_en     = 1'b0;
        cap_last   = 1'b0;
        fetch_en   = 1'b0;
        case (state)
            IDLE: if (start) state_next = CAPT;
            CAPT: begin
                if (start) begin
                    state_next = CAPT;
                end else if (in_valid) begin
                    cap_en = 1'b1;
                    if (replica_cnt == REP_MAX && beat_cnt == BEAT_MAX) begin
                        cap_last   = 1'b1;
                        fetch_en   = 1'b1;
                        state_next = READ;
                    end
                end
            end
            READ: begin
                if (start) begin
                    state_next = CAPT;
                end else begin
                    fetch_en = !fetch_all && (occ <= 2'd1);
                    if (pop && rd_last) state_next = DONE;
                end
            end
            DONE: if (start) state_next = CAPT;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the bitmap is built with blocking updates so later lanes see earlier lanes of the same beat.
    always_comb begin
        seen_next = (beat_cnt == '0) ? '0 : seen;
        beat_err  = 1'b0;
        city      = '0;
        for (int i = 0; i < LANES; i++) begin
            city = in_data[i*CITY_W +: CITY_W];
            if (int'(city) >= CITY_NUM)   beat_err = 1'b1;
            else if (seen_next[SW'(city)]) beat_err = 1'b1;
            else                           seen_next[SW'(city)] = 1'b1;
        end
    end

    // NOTE: the buffer and prefetch data have no reset; their valid flags make stale contents harmless.
    always_ff @(posedge clk) begin
        if (cap_en)   mem[{replica_cnt, beat_cnt}] <= in_data;
        if (fetch_en) pend_data <= mem[{fetch_rep, fetch_beat}];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            replica_cnt  <= '0;
            beat_cnt     <= '0;
            seen         <= '0;
            perm_err     <= '0;
            overrun      <= 1'b0;
            capture_done <= 1'b0;
            fetch_rep    <= '0;
            fetch_beat   <= '0;
            fetch_all    <= 1'b0;
            pend_valid   <= 1'b0;
            pend_rep     <= '0;
            pend_beat    <= '0;
            skid_valid   <= 1'b0;
            skid_data    <= '0;
            skid_rep     <= '0;
            skid_beat    <= '0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            rd_replica   <= '0;
            rd_beat      <= '0;
        end else if (start) begin
            replica_cnt  <= '0;
            beat_cnt     <= '0;
            perm_err     <= '0;
            overrun      <= 1'b0;
            capture_done <= 1'b0;
            fetch_rep    <= '0;
            fetch_beat   <= '0;
            fetch_all    <= 1'b0;
            pend_valid   <= 1'b0;
            skid_valid   <= 1'b0;
            rd_valid     <= 1'b0;
        end else begin
            capture_done <= cap_last;
            if (in_valid && state != CAPT) overrun <= 1'b1;

            if (cap_en) begin
                seen <= seen_next;
                if (beat_err) perm_err[replica_cnt] <= 1'b1;
                if (beat_cnt == BEAT_MAX) begin
                    beat_cnt    <= '0;
                    replica_cnt <= replica_cnt + RW'(1);
                end else begin
                    beat_cnt <= beat_cnt + BW'(1);
                end
            end

            if (fetch_en) begin
                pend_rep  <= fetch_rep;
                pend_beat <= fetch_beat;
                if (fetch_beat == BEAT_MAX) begin
                    fetch_beat <= '0;
                    if (fetch_rep == REP_MAX) fetch_all <= 1'b1;
                    else                      fetch_rep <= fetch_rep + RW'(1);
                end else begin
                    fetch_beat <= fetch_beat + BW'(1);
                end
            end
            pend_valid <= fetch_en;

            // Output register refills from the skid first, then from the arriving read.
            if (!rd_valid || pop) begin
                if (skid_valid) begin
                    rd_valid   <= 1'b1;
                    rd_data    <= skid_data;
                    rd_replica <= skid_rep;
                    rd_beat    <= skid_beat;
                    skid_valid <= pend_valid;
                    if (pend_valid) begin
                        skid_data <= pend_data;
                        skid_rep  <= pend_rep;
                        skid_beat <= pend_beat;
                    end
                end else begin
                    rd_valid <= pend_valid;
                    if (pend_valid) begin
                        rd_data    <= pend_data;
                        rd_replica <= pend_rep;
                        rd_beat    <= pend_beat;
                    end
                end
            end else if (pend_valid) begin
                skid_valid <= 1'b1;
                skid_data  <= pend_data;
                skid_rep   <= pend_rep;
                skid_beat  <= pend_beat;
            end
        end
    end

endmodule
